// File: rtl/cordic_rotator_if.sv
// cordic_rotator_if: job/result bundle for the CORDIC rotator.
//   master (upstream/bench): drives valid_in, angle_in, flips_in; sees results.
//   slave  (rotator)       : accepts the job, returns cos_out, sin_out, flips_out,
//                            done (one-cycle result strobe) and ready (idle).
interface cordic_rotator_if #(
    parameter int unsigned WIDTH = 32
);
    logic                    valid_in;
    logic signed [WIDTH-1:0] angle_in;
    logic signed [2:0]       flips_in;
    logic signed [WIDTH-1:0] cos_out;
    logic signed [WIDTH-1:0] sin_out;
    logic signed [2:0]       flips_out;
    logic                    done;
    logic                    ready;

    modport master (
        output valid_in, angle_in, flips_in,
        input  cos_out, sin_out, flips_out, done, ready
    );

    modport slave (
        input  valid_in, angle_in, flips_in,
        output cos_out, sin_out, flips_out, done, ready
    );
endinterface

// File: rtl/cordic_rotator.sv
// cordic_rotator: iterative rotation-mode CORDIC, one micro-rotation per cycle.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : cordic_rotator_if.slave -- job in (valid_in/angle_in/flips_in),
//          results out (cos_out/sin_out/flips_out), done pulse, ready (idle).
// Angle scale: 2^(WIDTH-2) = 45 deg. Result scale: 2^(WIDTH-2) = 1.0.
// done rises ITER+1 edges after the accepting edge; one job per ITER+2 cycles.
module cordic_rotator #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ITER  = 24
) (
    input logic             clk,
    input logic             rst,
    cordic_rotator_if.slave bus
);

    localparam int unsigned   CntW     = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CntW-1:0] LastIter = CntW'(ITER - 1);

    // round(0.6072529350 * 2^(WIDTH-2)), derived from the 2^32-scaled gain.
    function automatic logic [WIDTH-1:0] k_init();
        logic [63:0] k;
        k = 64'h0000_0000_9B74_EDA8;
        if (WIDTH < 34) begin
            k = k + (64'd1 << (33 - WIDTH));
            k = k >> (34 - WIDTH);
        end else if (WIDTH > 34) begin
            k = k << (WIDTH - 34);
        end
        return WIDTH'(k);
    endfunction

    // round(atan(2^-idx) * 4/pi * 2^(WIDTH-2)): Taylor series in 2^96 fixed
    // point, scaled by 4/pi held to 2^-64. Only ever called with constant
    // arguments, so it folds to a constant table.
    function automatic logic [WIDTH-1:0] atan_entry(input int unsigned idx);
        logic [191:0] s;
        logic [191:0] term;
        logic [191:0] prod;
        int           k;
        int           sh;
        int           shift;
        if (idx == 0) begin
            return WIDTH'(1) << (WIDTH - 2);
        end
        s  = '0;
        k  = 0;
        sh = 96 - int'(idx);
        while (sh >= 0) begin
            term = (192'd1 << sh) / 192'(2 * k + 1);
            if (k % 2 == 0) s = s + term;
            else            s = s - term;
            k  = k + 1;
            sh = 96 - int'(idx) * (2 * k + 1);
        end
        prod  = s * 192'h1_45F3_06DC_9C88_2A54;
        shift = 160 - (int'(WIDTH) - 2);
        prod  = prod + (192'd1 << (shift - 1));
        prod  = prod >> shift;
        return WIDTH'(prod);
    endfunction

    localparam logic [WIDTH-1:0] KInit = k_init();

    typedef enum logic [1:0] {StIdle, StIterate, StDone} state_e;

    state_e                  state_q, state_d;
    logic signed [WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic signed [WIDTH-1:0] x_sh, y_sh;
    logic signed [WIDTH-1:0] cos_q, cos_d, sin_q, sin_d;
    logic signed [2:0]       flips_q, flips_d, flips_out_q, flips_out_d;
    logic [CntW-1:0]         i_q, i_d;
    logic                    done_q, done_d;
    logic [WIDTH-1:0]        atan_tbl [ITER];

    for (genvar g = 0; g < ITER; g++) begin : g_atan
        assign atan_tbl[g] = atan_entry(g);
    end

    assign x_sh = x_q >>> i_q;
    assign y_sh = y_q >>> i_q;

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        i_d         = i_q;
        flips_d     = flips_q;
        cos_d       = cos_q;
        sin_d       = sin_q;
        flips_out_d = flips_out_q;
        done_d      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.valid_in) begin
                    z_d     = bus.angle_in;
                    flips_d = bus.flips_in;
                    x_d     = KInit;
                    y_d     = '0;
                    i_d     = '0;
                    state_d = StIterate;
                end
            end
            StIterate: begin
                // d = +1 when z >= 0: rotate counter-clockwise toward z = 0.
                if (!z_q[WIDTH-1]) begin
                    x_d = x_q - y_sh;
                    y_d = y_q + x_sh;
                    z_d = z_q - $signed(atan_tbl[i_q]);
                end else begin
                    x_d = x_q + y_sh;
                    y_d = y_q - x_sh;
                    z_d = z_q + $signed(atan_tbl[i_q]);
                end
                if (i_q == LastIter) begin
                    state_d = StDone;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            StDone: begin
                cos_d       = x_q;
                sin_d       = y_q;
                flips_out_d = flips_q;
                done_d      = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            i_q         <= '0;
            flips_q     <= '0;
            cos_q       <= '0;
            sin_q       <= '0;
            flips_out_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            i_q         <= i_d;
            flips_q     <= flips_d;
            cos_q       <= cos_d;
            sin_q       <= sin_d;
            flips_out_q <= flips_out_d;
            done_q      <= done_d;
        end
    end

    assign bus.cos_out   = cos_q;
    assign bus.sin_out   = sin_q;
    assign bus.flips_out = flips_out_q;
    assign bus.done      = done_q;
    assign bus.ready     = (state_q == StIdle);

endmodule
